bfly_stage1_sdf: RTL and testbench

// - Radix-2 butterfly stage directly downstream of the CBFP0 normaliser.
// - Consumes 16 normalised complex lanes per cycle (<5.6>, 11 b) for a 32-cycle frame.
// - Pairs each sample with the one DLY cycles later in the same lane.
// - Emits sums first, then differences; the downstream twiddle stage consumes both.
// - The frame block exponent (idx) is carried through, aligned with the frame's outputs.

---
 rtl/bfly_stage1_sdf.sv | 165 ++++++++++++++++
 tb/tb_bfly_stage1_sdf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_stage1_sdf.sv
// Radix-2 SDF butterfly stage: pairs each lane sample with the one DLY beats later,
// emitting sums then differences. Optional macro BFLY_OUT_REG_EN adds a second output register.
//
// state | meaning
// IDLE  | no frame in flight, waiting for the first valid beat
// FILL  | storing the first DLY beats of a frame
// BFLY  | each valid beat emits a sum and stores the difference
// DRAIN | emitting the DLY stored differences, one per cycle; may fill the next frame
module bfly_stage1_sdf #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 12,
    parameter int NCHAN = 16,
    parameter int DLY   = 16,
    parameter int IDX_W = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic [NCHAN-1:0][IN_W-1:0]       data_re_in,
    input  logic [NCHAN-1:0][IN_W-1:0]       data_im_in,
    input  logic [IDX_W-1:0]                 idx_in,
    output logic [NCHAN-1:0][OUT_W-1:0]      data_re_out,
    output logic [NCHAN-1:0][OUT_W-1:0]      data_im_out,
    output logic [IDX_W-1:0]                 idx_out,
    output logic                             valid_out,
    output logic                             frame_done
);
    localparam int AW = (DLY > 1) ? $clog2(DLY) : 1;
    localparam int CW = $clog2(DLY + 1);

    typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

    state_t            state, state_nxt, refill_state;
    logic [CW-1:0]     wr_cnt, fill_cnt_nxt;
    logic [AW-1:0]     rd_cnt;
    logic [IDX_W-1:0]  idx_sh;
    logic              fill_beat, bfly_beat, rd_last;

    logic [OUT_W-1:0]  mem_re [DLY][NCHAN];
    logic [OUT_W-1:0]  mem_im [DLY][NCHAN];

    logic [NCHAN-1:0][OUT_W-1:0] s1_re, s1_im, s1_re_nxt, s1_im_nxt;
    logic [IDX_W-1:0]            s1_idx, s1_idx_nxt;
    logic                        s1_valid, s1_valid_nxt, s1_done, s1_done_nxt;

    function automatic logic [OUT_W-1:0] sx(input logic [IN_W-1:0] x);
        return OUT_W'($signed(x));
    endfunction

    assign fill_beat    = valid_in && (state != BFLY);
    assign bfly_beat    = valid_in && (state == BFLY);
    assign rd_last      = (rd_cnt == AW'(DLY - 1));
    assign fill_cnt_nxt = wr_cnt + CW'(fill_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        if (fill_cnt_nxt == CW'(DLY))  refill_state = BFLY;
        else if (fill_cnt_nxt != '0)   refill_state = FILL;
        else                           refill_state = IDLE;

        state_nxt = state;
        unique case (state)
            IDLE, FILL: state_nxt = refill_state;
            BFLY:       if (bfly_beat && rd_last) state_nxt = DRAIN;
            DRAIN:      if (rd_last) state_nxt = refill_state;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            idx_sh <= '0;
        end else begin
            if (state != BFLY && state_nxt == BFLY) wr_cnt <= '0;
            else if (fill_beat)                     wr_cnt <= fill_cnt_nxt;
            if (bfly_beat || state == DRAIN)
                rd_cnt <= rd_last ? '0 : rd_cnt + AW'(1);
            // exponent of the next frame waits here until its first sum goes out
            if (fill_beat && wr_cnt == '0) idx_sh <= idx_in;
        end
    end

    // Read-before-write: the DRAIN read and the next-frame fill may share an address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (fill_beat) begin
                mem_re[wr_cnt[AW-1:0]][i] <= sx(data_re_in[i]);
                mem_im[wr_cnt[AW-1:0]][i] <= sx(data_im_in[i]);
            end else if (bfly_beat) begin
                mem_re[rd_cnt][i] <= mem_re[rd_cnt][i] - sx(data_re_in[i]);
                mem_im[rd_cnt][i] <= mem_im[rd_cnt][i] - sx(data_im_in[i]);
            end
        end
    end

    always_comb begin
        s1_re_nxt    = s1_re;
        s1_im_nxt    = s1_im;
        s1_idx_nxt   = s1_idx;
        s1_valid_nxt = 1'b0;
        s1_done_nxt  = 1'b0;
        if (bfly_beat) begin
            for (int i = 0; i < NCHAN; i++) begin
                s1_re_nxt[i] = mem_re[rd_cnt][i] + sx(data_re_in[i]);
                s1_im_nxt[i] = mem_im[rd_cnt][i] + sx(data_im_in[i]);
            end
            if (rd_cnt == '0) s1_idx_nxt = idx_sh;
            s1_valid_nxt = 1'b1;
        end else if (state == DRAIN) begin
            for (int i = 0; i < NCHAN; i++) begin
                s1_re_nxt[i] = mem_re[rd_cnt][i];
                s1_im_nxt[i] = mem_im[rd_cnt][i];
            end
            s1_valid_nxt = 1'b1;
            s1_done_nxt  = rd_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_re    <= '0;
            s1_im    <= '0;
            s1_idx   <= '0;
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
        end else begin
            s1_re    <= s1_re_nxt;
            s1_im    <= s1_im_nxt;
            s1_idx   <= s1_idx_nxt;
            s1_valid <= s1_valid_nxt;
            s1_done  <= s1_done_nxt;
        end
    end

`ifdef BFLY_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_re_out <= '0;
            data_im_out <= '0;
            idx_out     <= '0;
            valid_out   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            data_re_out <= s1_re;
            data_im_out <= s1_im;
            idx_out     <= s1_idx;
            valid_out   <= s1_valid;
            frame_done  <= s1_done;
        end
    end
`else
    assign data_re_out = s1_re;
    assign data_im_out = s1_im;
    assign idx_out     = s1_idx;
    assign valid_out   = s1_valid;
    assign frame_done  = s1_done;
`endif

endmodule

// File: tb/tb_bfly_stage1_sdf.sv
// Testbench for bfly_stage1_sdf: directed frame sequences with random lane data,
// checked against a frame-level sum/difference model with expected output cycles.
module tb_bfly_stage1_sdf;
    localparam int IN_W  = 11;
    localparam int OUT_W = 12;
    localparam int NCHAN = 16;
    localparam int DLY   = 16;
    localparam int IDX_W = 5;
    localparam int W     = NCHAN * OUT_W;
`ifdef BFLY_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          valid_in;
    logic [NCHAN-1:0][IN_W-1:0]    data_re_in, data_im_in;
    logic [IDX_W-1:0]              idx_in;
    logic [NCHAN-1:0][OUT_W-1:0]   data_re_out, data_im_out;
    logic [IDX_W-1:0]              idx_out;
    logic                          valid_out, frame_done;

    bfly_stage1_sdf #(.IN_W(IN_W), .OUT_W(OUT_W), .NCHAN(NCHAN), .DLY(DLY), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .data_re_in(data_re_in), .data_im_in(data_im_in), .idx_in(idx_in),
        .data_re_out(data_re_out), .data_im_out(data_im_out), .idx_out(idx_out),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [W-1:0]     re;
        logic [W-1:0]     im;
        logic [IDX_W-1:0] idx;
        logic             done;
    } beat_t;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t cap_q[$];
    beat_t exp_q[$];
    beat_t mon_b;

    logic signed [IN_W-1:0] fr_re [2*DLY][NCHAN];
    logic signed [IN_W-1:0] fr_im [2*DLY][NCHAN];
    int                     fr_cyc [2*DLY];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            mon_b.cyc  = cyc;
            mon_b.re   = data_re_out;
            mon_b.im   = data_im_out;
            mon_b.idx  = idx_out;
            mon_b.done = frame_done;
            cap_q.push_back(mon_b);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: random; 1: lane0 re = beat index, im = 0; 2: all -1024
    task automatic gen_frame(input int mode);
        for (int b = 0; b < 2*DLY; b++)
            for (int i = 0; i < NCHAN; i++) begin
                fr_re[b][i] = IN_W'($urandom);
                fr_im[b][i] = IN_W'($urandom);
                if (mode == 1 && i == 0) begin
                    fr_re[b][i] = IN_W'(b);
                    fr_im[b][i] = '0;
                end
                if (mode == 2) begin
                    fr_re[b][i] = -11'sd1024;
                    fr_im[b][i] = -11'sd1024;
                end
            end
    endtask

    task automatic drive_frame(input logic [IDX_W-1:0] idx, input int n_beats,
                               input int g1, input int g2, input int glen);
        beat_t e;
        int    a, b2, last_sum;
        for (int b = 0; b < n_beats; b++) begin
            if (b == g1 || b == g2)
                repeat (glen) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                end
            @(negedge clk);
            valid_in = 1'b1;
            idx_in   = idx;
            for (int i = 0; i < NCHAN; i++) begin
                data_re_in[i] = fr_re[b][i];
                data_im_in[i] = fr_im[b][i];
            end
            fr_cyc[b] = cyc;
        end
        if (n_beats == 2*DLY) begin
            last_sum = fr_cyc[2*DLY-1] + LAT;
            for (int j = 0; j < 2*DLY; j++) begin
                int k;
                k = (j < DLY) ? j : j - DLY;
                e.cyc  = (j < DLY) ? fr_cyc[DLY+j] + LAT : last_sum + 1 + k;
                e.idx  = idx;
                e.done = (j == 2*DLY-1);
                for (int i = 0; i < NCHAN; i++) begin
                    a  = int'(fr_re[k][i]);
                    b2 = int'(fr_re[k+DLY][i]);
                    e.re[i*OUT_W +: OUT_W] = OUT_W'((j < DLY) ? a + b2 : a - b2);
                    a  = int'(fr_im[k][i]);
                    b2 = int'(fr_im[k+DLY][i]);
                    e.im[i*OUT_W +: OUT_W] = OUT_W'((j < DLY) ? a + b2 : a - b2);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic compare_run(input string tag, input int base);
        beat_t c;
        chk($sformatf("%s beat count", tag), W'(cap_q.size() - base), W'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++) begin
            c = (base + j < cap_q.size()) ? cap_q[base+j] : '{default: '0};
            chk($sformatf("%s beat %0d cycle", tag, j), W'(c.cyc), W'(exp_q[j].cyc));
            chk($sformatf("%s beat %0d re", tag, j), c.re, exp_q[j].re);
            chk($sformatf("%s beat %0d im", tag, j), c.im, exp_q[j].im);
            chk($sformatf("%s beat %0d idx", tag, j), W'(c.idx), W'(exp_q[j].idx));
            chk($sformatf("%s beat %0d done", tag, j), W'(c.done), W'(exp_q[j].done));
        end
    endtask

    task automatic lane0_checks(input string tag, input int base);
        beat_t t;
        t = cap_q[base];
        chk({tag, " lane0 first sum"}, W'(t.re[OUT_W-1:0]), W'(16));
        t = cap_q[base+DLY-1];
        chk({tag, " lane0 last sum"}, W'(t.re[OUT_W-1:0]), W'(46));
        t = cap_q[base+DLY];
        chk({tag, " lane0 first diff"}, W'(t.re[OUT_W-1:0]), W'(12'hff0));
        chk({tag, " lane0 first diff im"}, W'(t.im[OUT_W-1:0]), W'(0));
        t = cap_q[base+2*DLY-1];
        chk({tag, " frame_done last beat"}, W'(t.done), W'(1));
        chk({tag, " idx"}, W'(t.idx), W'(7));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    base;
        beat_t t, t0;

        rst = 1'b1; valid_in = 1'b0; idx_in = '0;
        data_re_in = '0; data_im_in = '0;
        repeat (3) @(negedge clk);
        chk("reset valid_out", W'(valid_out), W'(0));
        chk("reset frame_done", W'(frame_done), W'(0));
        chk("reset idx_out", W'(idx_out), W'(0));
        chk("reset data_re", data_re_out, '0);
        chk("reset data_im", data_im_out, '0);
        rst = 1'b0;
        idle(2);

        // single frame, lane0 ramp
        base = cap_q.size(); exp_q.delete();
        gen_frame(1);
        drive_frame(5'd7, 2*DLY, -1, -1, 0);
        idle(DLY + 6);
        compare_run("single", base);
        lane0_checks("single", base);

        // extremes
        base = cap_q.size(); exp_q.delete();
        gen_frame(2);
        drive_frame(5'd21, 2*DLY, -1, -1, 0);
        idle(DLY + 6);
        compare_run("extreme", base);
        t = cap_q[base];
        chk("extreme sum re", t.re, {NCHAN{12'h800}});
        t = cap_q[base+DLY];
        chk("extreme diff im", t.im, '0);

        // back-to-back frames
        base = cap_q.size(); exp_q.delete();
        gen_frame(0);
        drive_frame(5'd3, 2*DLY, -1, -1, 0);
        gen_frame(0);
        drive_frame(5'd9, 2*DLY, -1, -1, 0);
        idle(DLY + 6);
        compare_run("b2b", base);
        t0 = cap_q[base];
        t  = cap_q[base+4*DLY-1];
        chk("b2b contiguous span", W'(t.cyc - t0.cyc), W'(4*DLY-1));
        t = cap_q[base+2*DLY-1];
        chk("b2b idx beat 31", W'(t.idx), W'(3));
        t = cap_q[base+2*DLY];
        chk("b2b idx beat 32", W'(t.idx), W'(9));

        // gaps in FILL and BFLY
        base = cap_q.size(); exp_q.delete();
        gen_frame(1);
        drive_frame(5'd7, 2*DLY, 5, 20, 3);
        idle(DLY + 6);
        compare_run("gaps", base);
        lane0_checks("gaps", base);

        // mid-frame asynchronous reset
        gen_frame(0);
        drive_frame(5'd12, 20, -1, -1, 0);
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async reset valid_out", W'(valid_out), W'(0));
        chk("async reset data_re", data_re_out, '0);
        chk("async reset idx_out", W'(idx_out), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
        base = cap_q.size(); exp_q.delete();
        gen_frame(1);
        drive_frame(5'd7, 2*DLY, -1, -1, 0);
        idle(DLY + 6);
        compare_run("post-reset", base);
        lane0_checks("post-reset", base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
